// File: rtl/ucode_pkg.sv
// Shared constants for the microcode sequencer: fixed microstate numbers,
// next-state select encodings and interrupt vector encodings.
package ucode_pkg;

  localparam int ST_RESET        = 0;
  localparam int ST_BR_TAKEN     = 67;
  localparam int ST_BR_NOT_TAKEN = 4;
  localparam int ST_NMI          = 70;
  localparam int ST_IRQ          = 71;

  typedef enum logic [1:0] {
    SEL_NEXT   = 2'd0,
    SEL_OP     = 2'd1,
    SEL_BRANCH = 2'd2,
    SEL_HOLD   = 2'd3
  } st_sel_e;

  typedef enum logic [1:0] {
    INT_NONE = 2'd0,
    INT_IRQ  = 2'd1,
    INT_NMI  = 2'd2
  } int_vec_e;

endpackage

// File: rtl/int_arbiter.sv
// Interrupt capture and priority: NMI edge latch, IRQ masking, entry decision
// at instruction boundaries and the registered vector of the one in service.
module int_arbiter
  import ucode_pkg::*;
(
  input  logic       ph1,
  input  logic       reset,
  input  logic       rdy,
  input  logic       nmi,
  input  logic       irq,
  input  logic       irq_mask,
  input  logic       st_last,
  output logic       enter_nmi,
  output logic       enter_irq,
  output logic [1:0] int_vec
);

  logic nmi_prev;
  logic nmi_pend;
  logic nmi_edge;

  assign nmi_edge  = nmi & ~nmi_prev;
  assign enter_nmi = rdy & st_last & (nmi_pend | nmi_edge);
  assign enter_irq = rdy & st_last & ~enter_nmi & irq & ~irq_mask;

  // Edge history runs every edge, so NMI is captured even while stalled.
  // On entry the pending flag is consumed, but an edge seen in the same
  // cycle as an already pending NMI is kept for the next boundary.
  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      nmi_prev <= 1'b0;
      nmi_pend <= 1'b0;
      int_vec  <= INT_NONE;
    end else begin
      nmi_prev <= nmi;
      if (enter_nmi) nmi_pend <= nmi_pend & nmi_edge;
      else           nmi_pend <= nmi_pend | nmi_edge;
      if (rdy && st_last) begin
        if (enter_nmi)      int_vec <= INT_NMI;
        else if (enter_irq) int_vec <= INT_IRQ;
        else                int_vec <= INT_NONE;
      end
    end
  end

endmodule

// File: rtl/ucode_sequencer.sv
// Microcode sequencer: selects the next ROM state, latches the opcode at fetch,
// registers the control word and forces interrupt entry at instruction ends.
module ucode_sequencer
  import ucode_pkg::*;
#(
  parameter int STATE_W = 8,
  parameter int CTRL_W  = 46,
  parameter int OPC_W   = 14,
  parameter logic [STATE_W-1:0] RESET_STATE        = STATE_W'(ST_RESET),
  parameter logic [STATE_W-1:0] BR_TAKEN_STATE     = STATE_W'(ST_BR_TAKEN),
  parameter logic [STATE_W-1:0] BR_NOT_TAKEN_STATE = STATE_W'(ST_BR_NOT_TAKEN),
  parameter logic [STATE_W-1:0] NMI_STATE          = STATE_W'(ST_NMI),
  parameter logic [STATE_W-1:0] IRQ_STATE          = STATE_W'(ST_IRQ)
) (
  input  logic                    ph1,
  input  logic                    reset,
  input  logic                    rdy,
  input  logic [7:0]              data_in,
  input  logic [7:0]              p,
  input  logic                    nmi,
  input  logic                    irq,
  input  logic [STATE_W-1:0]      st_next,
  input  logic [1:0]              st_sel,
  input  logic                    st_last,
  input  logic                    st_opsel,
  input  logic [CTRL_W-OPC_W-1:0] st_ctrl,
  input  logic [OPC_W-1:0]        st_opctrl,
  input  logic [STATE_W-1:0]      op_next,
  input  logic [OPC_W-1:0]        op_ctrl,
  input  logic [7:0]              br_mask,
  input  logic                    br_pol,
  output logic [STATE_W-1:0]      state,
  output logic [7:0]              opcode,
  output logic [CTRL_W-1:0]       ctrl,
  output logic                    first_cycle,
  output logic [1:0]              int_vec
);

  logic               enter_nmi;
  logic               enter_irq;
  logic               taken;
  logic [STATE_W-1:0] next_state;

  int_arbiter u_int_arbiter (
    .ph1       (ph1),
    .reset     (reset),
    .rdy       (rdy),
    .nmi       (nmi),
    .irq       (irq),
    .irq_mask  (p[2]),
    .st_last   (st_last),
    .enter_nmi (enter_nmi),
    .enter_irq (enter_irq),
    .int_vec   (int_vec)
  );

  assign taken = ((|(p & br_mask)) == br_pol);

  always_comb begin
    next_state = state;
    case (st_sel_e'(st_sel))
      SEL_NEXT:   next_state = st_next;
      SEL_OP:     next_state = op_next;
      SEL_BRANCH: next_state = taken ? BR_TAKEN_STATE : BR_NOT_TAKEN_STATE;
      default:    next_state = state;
    endcase
  end

  // Interrupt entry overrides both the state select and the opcode fetch.
  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      state       <= RESET_STATE;
      opcode      <= 8'h00;
      ctrl        <= '0;
      first_cycle <= 1'b0;
    end else if (rdy) begin
      if (enter_nmi)      state <= NMI_STATE;
      else if (enter_irq) state <= IRQ_STATE;
      else                state <= next_state;
      if (enter_nmi || enter_irq) opcode <= 8'h00;
      else if (first_cycle)       opcode <= data_in;
      ctrl        <= {st_ctrl, st_opsel ? op_ctrl : st_opctrl};
      first_cycle <= st_last;
    end
  end

endmodule

// File: doc/ucode_sequencer.md
UCODE_SEQUENCER -- requirements
Module: ucode_sequencer

Interface
REQ-001 SHALL have parameter STATE_W, default 8, width of microstate number.
REQ-002 SHALL have parameter CTRL_W, default 46, width of registered control word (state part + opcode part).
REQ-003 SHALL have parameter OPC_W, default 14, width of opcode-specific control field inside CTRL_W.
REQ-004 SHALL have parameters RESET_STATE 0, BR_TAKEN_STATE 67, BR_NOT_TAKEN_STATE 4, NMI_STATE 70, IRQ_STATE 71 (all STATE_W wide).
REQ-005 SHALL have ports, in order:
- ph1  in  1  single clock, rising edge active
- reset  in  1  asynchronous, active-low
- rdy  in  1  1 = advance, 0 = stall all state
- data_in  in  8  opcode byte from bus
- p  in  8  processor status flags
- nmi  in  1  non-maskable interrupt request, edge-sensitive
- irq  in  1  maskable interrupt request, level, masked by p[2]
- st_next  in  STATE_W  next state from state ROM
- st_sel  in  2  next-state select (0 st_next, 1 op_next, 2 branch, 3 hold)
- st_last  in  1  current state is last cycle of instruction
- st_opsel  in  1  1 = use opcode control field
- st_ctrl  in  CTRL_W-OPC_W  state control field
- st_opctrl  in  OPC_W  state-supplied opcode field
- op_next  in  STATE_W  dispatch state from opcode ROM
- op_ctrl  in  OPC_W  opcode ROM control field
- br_mask  in  8  flag select for branch
- br_pol  in  1  branch taken polarity
- state  out  STATE_W  current microstate (ROM address)
- opcode  out  8  latched opcode (opcode ROM address)
- ctrl  out  CTRL_W  registered control word
- first_cycle  out  1  current cycle is opcode fetch
- int_vec  out  2  0 none, 1 IRQ, 2 NMI being serviced

Function
REQ-006 SHALL update state, opcode, ctrl, first_cycle and int_vec only on ph1 rising edge with rdy=1; with rdy=0 all hold; NMI edge capture continues during stall.
REQ-007 SHALL compute next state: st_sel 0 st_next; 1 op_next; 2 BR_TAKEN_STATE if taken else BR_NOT_TAKEN_STATE; 3 current state.
REQ-008 SHALL define taken = ((|(p & br_mask)) == br_pol).
REQ-009 SHALL register first_cycle <= st_last; opcode SHALL load data_in on edge where first_cycle=1 and no interrupt is being entered.
REQ-010 SHALL register ctrl <= {st_ctrl, st_opsel ? op_ctrl : st_opctrl}, one cycle latency from state.
REQ-011 SHALL detect NMI as 0->1 transition of nmi between consecutive ph1 edges, setting nmi_pend; nmi_pend clears only on NMI entry.
REQ-012 SHALL sample interrupts on edge where st_last=1: nmi_pend wins; else irq=1 and p[2]=0; next state forced to NMI_STATE/IRQ_STATE, opcode loaded 8'h00, int_vec set 2/1, overriding st_sel.
REQ-013 SHALL clear int_vec to 0 on next edge where st_last=1 with no new entry.
REQ-014 SHALL treat NMI edge arriving same cycle as entry as pending for next instruction boundary.
REQ-015 SHALL wrap nothing: state values beyond ROM range are caller's responsibility; no saturation.

Reset
REQ-016 SHALL on reset=0 asynchronously set state RESET_STATE, opcode 8'h00, ctrl 0, first_cycle 0, int_vec 0, nmi_pend 0, NMI edge history 0.
REQ-017 SHALL, on reset release mid-instruction, resume from RESET_STATE on first ph1 edge with rdy=1.

Structure
REQ-018 SHALL place state-number constants, st_sel encodings and int_vec encodings in shared package ucode_pkg.
REQ-019 SHALL implement interrupt capture/priority as sub-module int_arbiter; remainder flat.

Verification
REQ-020 Reset asserted mid-run, released -> state=0, opcode=00, ctrl=0 immediately; advances from state 0 on next edge.
REQ-021 st_sel=2, br_mask=8'h02, br_pol=1, p=8'h02 -> state 67; p=8'h00 -> state 4.
REQ-022 rdy=0 for 3 edges during st_sel=0, st_next=9 -> state, ctrl unchanged; after rdy=1 -> state 9.
REQ-023 st_last=1, irq=1, p[2]=0, nmi pulse same cycle -> state 70, int_vec=2, opcode=00; irq still high at next boundary -> state 71, int_vec=1.
REQ-024 irq=1, p=8'h04 at boundary -> no entry; opcode=data_in (8'hA9) on fetch edge, state=op_next.
REQ-025 st_opsel toggled 0/1 with op_ctrl=14'h3FFF, st_opctrl=0 -> ctrl low field 0/3FFF one edge later.
